erode_3x3_lb: RTL and testbench
===============================

// Module: erode_3x3_lb
// PURPOSE
//  3x3 binary erosion on a raster video stream (de/hsync/vsync/data).
//  Morphological dual of the ISP dilation stage: output pixel is set only if all nine window pixels are set.
//  Self-contained: owns its two line buffers, column/row counters and frame-edge masking.
//  Sits between binarisation and dilation (opening = erode then dilate).
// PARAMETERS
//  H_DISP      12'd480  active pixels per line (line-buffer depth, col counter range)
//  V_DISP      12'd272  active lines per frame (row counter range)
//  BORDER_VAL  1'b1     value used for window taps outside the frame (1 = no edge shrink, 0 = edges cleared)
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  reset, asynchronous, active-low
//  erode_en     in   1  1 = erode, 0 = bypass (binarised passthrough); sampled per frame
//  bina_de      in   1  input data enable, high for H_DISP cycles per line
//  bina_hsync   in   1  input line sync (delayed only)
//  bina_vsync   in   1  input frame sync, active-high; rising edge = frame start
//  bina_data    in   8  input pixel; bit = (bina_data != 8'h00)
//  erode_de     out  1  bina_de delayed 3 clk
//  erode_hsync  out  1  bina_hsync delayed 3 clk
//  erode_vsync  out  1  bina_vsync delayed 3 clk
//  erode_data   out  8  8'hFF if result bit = 1, else 8'h00
// BEHAVIOUR
//  Reset: every output = 0, counters = 0, sync delay lines = 0, en_frame = 0, window regs = 0.
//   Line-buffer contents are not cleared.
//  Pixel bit p = |bina_data. Only de-high cycles are pixels; de-low cycles never shift the window or write the buffers.
//  Counters:
//   - col 0..H_DISP-1: increments on each de-high cycle, cleared on the de falling edge.
//   - row 0..V_DISP-1: increments on the de falling edge, saturates at V_DISP-1.
//   - Both counters clear on the vsync rising edge.
//   - Vsync rising edge coincident with de: the clear wins, and that pixel is taken as (0,0).
//  Line buffers: lb0 holds row r-1, lb1 holds row r-2, addressed by col.
//   - On each pixel: read lb0[col] and lb1[col], write lb1[col] <= lb0[col] and lb0[col] <= p (read-before-write).
//   - Implemented as reg arrays or inferred single-port RAM with read-first.
//  Window: 3x3 with current pixel (r,c) at the bottom-right. Taps are rows r-2..r, cols c-2..c.
//   - Any tap with row < 0 or col < 0 is replaced by BORDER_VAL; masking comes from the counters.
//   - No right/bottom padding.
//  Pipeline, fixed 3-clk latency, independent of erode_en:
//   - clk1: buffer read and window shift.
//   - clk2: per-row AND of 3 taps (with masks applied).
//   - clk3: AND of the 3 row results, or the bypass bit.
//  Bypass: erode_en is latched into en_frame on the vsync rising edge only. A mid-frame toggle takes effect next frame.
//   - en_frame = 0: result = the centre-of-pipeline copy of p (same 3-clk latency).
//  Sync: de/hsync/vsync pass through 3-stage shift registers, exactly aligned with erode_data.
//  Overflow: more than H_DISP de-high cycles in a line holds col at H_DISP-1 (buffer address never exceeds depth-1).
//   Output stays defined, content unspecified.
//  Reset mid-frame: outputs go to 0 immediately (async). After release, output is valid from the next vsync rising edge.
// TESTING
//  1. All-0xFF frame, BORDER_VAL=1, en=1 -> every de-high output 8'hFF; de/hs/vs = input delayed exactly 3 clk.
//  2. All-0xFF frame, BORDER_VAL=0 -> output 0x00 for rows 0-1 and cols 0-1, 0xFF elsewhere.
//  3. Single 0x00 pixel at (10,20) in an all-0xFF frame -> 0x00 at output coords rows 10-12 x cols 20-22 (9 pixels), rest 0xFF.
//  4. Single 0xFF pixel in an all-0x00 frame -> output all 0x00. Same frame with en=0 -> exactly that pixel 0xFF, at the same latency.
//  5. Toggle erode_en mid-frame -> current frame unchanged; mode switches at the next vsync rising edge.
//  6. Assert rst_n mid-line -> all outputs 0 in the same cycle. Next full frame matches the golden model bit-exactly.

Source files
------------

// File: rtl/erode_3x3_lb.sv
`timescale 1ns / 1ps
// erode_3x3_lb
//   3x3 binary erosion on a raster video stream. A pixel is "set" when its 8-bit
//   input value is non-zero. The output pixel is set only if all nine taps of the
//   window are set. The current pixel sits at the bottom-right corner of the window.
//   The block owns its two line buffers, its column/row counters and the
//   frame-edge masking. Latency is a fixed 3 clocks, with or without erosion.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   erode_en     in   1 = erode, 0 = binarised bypass; taken at each vsync rising edge
//   bina_de      in   input data enable (one pixel per high cycle)
//   bina_hsync   in   input line sync (delayed only)
//   bina_vsync   in   input frame sync; its rising edge starts a frame
//   bina_data    in   input pixel; the bit is (bina_data != 0)
//   erode_de     out  bina_de delayed 3 clocks
//   erode_hsync  out  bina_hsync delayed 3 clocks
//   erode_vsync  out  bina_vsync delayed 3 clocks
//   erode_data   out  8'hFF when the result bit is set, else 8'h00 (also 8'h00 when de is low)
module erode_3x3_lb #(
  parameter int unsigned H_DISP     = 480,
  parameter int unsigned V_DISP     = 272,
  parameter logic        BORDER_VAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       erode_en,
  input  logic       bina_de,
  input  logic       bina_hsync,
  input  logic       bina_vsync,
  input  logic [7:0] bina_data,
  output logic       erode_de,
  output logic       erode_hsync,
  output logic       erode_vsync,
  output logic [7:0] erode_data
);

  localparam int unsigned CW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int unsigned RW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(H_DISP - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_DISP - 1);

  // ---------------------------------------------------------------------------
  // Sync delay lines (stage 1 and 2 here, stage 3 drives the outputs)
  // ---------------------------------------------------------------------------
  logic de_s1, de_s2;
  logic hs_s1, hs_s2;
  logic vs_s1, vs_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1 <= 1'b0;
      de_s2 <= 1'b0;
      hs_s1 <= 1'b0;
      hs_s2 <= 1'b0;
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
    end else begin
      de_s1 <= bina_de;
      de_s2 <= de_s1;
      hs_s1 <= bina_hsync;
      hs_s2 <= hs_s1;
      vs_s1 <= bina_vsync;
      vs_s2 <= vs_s1;
    end
  end

  // Edge detects reuse the first sync stage as the "previous" value.
  logic vs_rise;
  logic de_fall;
  logic pix_bit;

  assign vs_rise = bina_vsync & ~vs_s1;
  assign de_fall = de_s1 & ~bina_de;
  assign pix_bit = |bina_data;

  // ---------------------------------------------------------------------------
  // Column / row counters and per-frame enable
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d, col_base;
  logic [RW-1:0] row_q, row_d, row_base;
  logic          en_frame_q, en_frame_d;

  // A vsync rising edge clears the counters before the current cycle uses them,
  // so a pixel arriving on that same cycle is treated as (0,0).
  always_comb begin
    col_base   = vs_rise ? '0 : col_q;
    row_base   = vs_rise ? '0 : row_q;
    col_d      = col_base;
    row_d      = row_base;
    en_frame_d = vs_rise ? erode_en : en_frame_q;
    if (bina_de) begin
      // Saturate so an over-long line never addresses past the buffer end.
      col_d = (col_base == COL_MAX) ? COL_MAX : col_base + CW'(1);
    end else if (de_fall && !vs_rise) begin
      col_d = '0;
      row_d = (row_base == ROW_MAX) ? ROW_MAX : row_base + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      en_frame_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      en_frame_q <= en_frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 = row r-1, lb1 = row r-2. Read-before-write, not reset.
  // ---------------------------------------------------------------------------
  logic lb0 [0:H_DISP-1];
  logic lb1 [0:H_DISP-1];
  logic lb0_rd;
  logic lb1_rd;

  assign lb0_rd = lb0[col_base];
  assign lb1_rd = lb1[col_base];

  always_ff @(posedge clk) begin
    if (bina_de) begin
      lb0[col_base] <= pix_bit;
      lb1[col_base] <= lb0_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: window shift. Bit 2 = column c, bit 1 = c-1, bit 0 = c-2.
  // win_r2 = row r, win_r1 = row r-1, win_r0 = row r-2.
  // ---------------------------------------------------------------------------
  logic [2:0] win_r0_q, win_r0_d;
  logic [2:0] win_r1_q, win_r1_d;
  logic [2:0] win_r2_q, win_r2_d;
  logic       c_lt1_q, c_lt1_d;
  logic       c_lt2_q, c_lt2_d;
  logic       r_lt1_q, r_lt1_d;
  logic       r_lt2_q, r_lt2_d;
  logic       en_s1_q, en_s1_d;
  logic       vld_s1_q, vld_s1_d;

  always_comb begin
    win_r0_d = win_r0_q;
    win_r1_d = win_r1_q;
    win_r2_d = win_r2_q;
    c_lt1_d  = c_lt1_q;
    c_lt2_d  = c_lt2_q;
    r_lt1_d  = r_lt1_q;
    r_lt2_d  = r_lt2_q;
    en_s1_d  = en_s1_q;
    vld_s1_d = bina_de;
    if (bina_de) begin
      win_r2_d = {pix_bit, win_r2_q[2:1]};
      win_r1_d = {lb0_rd, win_r1_q[2:1]};
      win_r0_d = {lb1_rd, win_r0_q[2:1]};
      c_lt1_d  = (col_base == '0);
      c_lt2_d  = (col_base <= CW'(1));
      r_lt1_d  = (row_base == '0);
      r_lt2_d  = (row_base <= RW'(1));
      en_s1_d  = en_frame_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r0_q <= '0;
      win_r1_q <= '0;
      win_r2_q <= '0;
      c_lt1_q  <= 1'b0;
      c_lt2_q  <= 1'b0;
      r_lt1_q  <= 1'b0;
      r_lt2_q  <= 1'b0;
      en_s1_q  <= 1'b0;
      vld_s1_q <= 1'b0;
    end else begin
      win_r0_q <= win_r0_d;
      win_r1_q <= win_r1_d;
      win_r2_q <= win_r2_d;
      c_lt1_q  <= c_lt1_d;
      c_lt2_q  <= c_lt2_d;
      r_lt1_q  <= r_lt1_d;
      r_lt2_q  <= r_lt2_d;
      en_s1_q  <= en_s1_d;
      vld_s1_q <= vld_s1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: edge masking and per-row AND
  // ---------------------------------------------------------------------------
  logic [2:0] col_mask;
  logic [2:0] r1_mask;
  logic [2:0] r0_mask;
  logic [2:0] tap_r0, tap_r1, tap_r2;
  logic [2:0] row_and_q, row_and_d;
  logic       byp_q;
  logic       en_s2_q;
  logic       vld_s2_q;

  always_comb begin
    col_mask     = {1'b0, c_lt1_q, c_lt2_q};
    r1_mask      = r_lt1_q ? 3'b111 : col_mask;
    r0_mask      = r_lt2_q ? 3'b111 : col_mask;
    tap_r2       = (win_r2_q & ~col_mask) | ({3{BORDER_VAL}} & col_mask);
    tap_r1       = (win_r1_q & ~r1_mask) | ({3{BORDER_VAL}} & r1_mask);
    tap_r0       = (win_r0_q & ~r0_mask) | ({3{BORDER_VAL}} & r0_mask);
    row_and_d    = {&tap_r2, &tap_r1, &tap_r0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_and_q <= '0;
      byp_q     <= 1'b0;
      en_s2_q   <= 1'b0;
      vld_s2_q  <= 1'b0;
    end else begin
      row_and_q <= row_and_d;
      byp_q     <= win_r2_q[2];
      en_s2_q   <= en_s1_q;
      vld_s2_q  <= vld_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: final AND or bypass bit, registered outputs
  // ---------------------------------------------------------------------------
  logic       res_bit;
  logic [7:0] data_d;

  always_comb begin
    res_bit = en_s2_q ? (&row_and_q) : byp_q;
    data_d  = (vld_s2_q && res_bit) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erode_de    <= 1'b0;
      erode_hsync <= 1'b0;
      erode_vsync <= 1'b0;
      erode_data  <= 8'h00;
    end else begin
      erode_de    <= de_s2;
      erode_hsync <= hs_s2;
      erode_vsync <= vs_s2;
      erode_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_erode_3x3_lb.sv
`timescale 1ns / 1ps
module tb_erode_3x3_lb;

  localparam int H = 24;
  localparam int V = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       erode_en;
  logic       de, hs, vs;
  logic [7:0] din;

  logic       de1, hs1, vs1;
  logic [7:0] dout1;
  logic       de0, hs0, vs0;
  logic [7:0] dout0;

  always #5 clk = ~clk;

  erode_3x3_lb #(.H_DISP(H), .V_DISP(V), .BORDER_VAL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .erode_en(erode_en),
    .bina_de(de), .bina_hsync(hs), .bina_vsync(vs), .bina_data(din),
    .erode_de(de1), .erode_hsync(hs1), .erode_vsync(vs1), .erode_data(dout1)
  );

  erode_3x3_lb #(.H_DISP(H), .V_DISP(V), .BORDER_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .erode_en(erode_en),
    .bina_de(de), .bina_hsync(hs), .bina_vsync(vs), .bina_data(din),
    .erode_de(de0), .erode_hsync(hs0), .erode_vsync(vs0), .erode_data(dout0)
  );

  bit         img  [V][H];
  logic [7:0] cap1 [V][H];
  logic [7:0] cap0 [V][H];
  int         total = 0;
  int         bad   = 0;
  int         sync_err;

  // Input history: index 0 = newest, 2 = the input whose result is visible now.
  logic hde [3];
  logic hhs [3];
  logic hvs [3];
  int   hr  [3];
  int   hc  [3];

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hde[i] = 1'b0; hhs[i] = 1'b0; hvs[i] = 1'b0; hr[i] = 0; hc[i] = 0;
    end
    sync_err = 0;
  endtask

  // One clock: drive inputs, step, then record what came out for the input
  // driven two calls earlier (3 clocks of latency counting its capture edge).
  task automatic cycle(input logic d, input logic h, input logic v, input logic [7:0] x,
                       input int r, input int c);
    de = d; hs = h; vs = v; din = x;
    for (int i = 2; i > 0; i--) begin
      hde[i] = hde[i-1]; hhs[i] = hhs[i-1]; hvs[i] = hvs[i-1]; hr[i] = hr[i-1]; hc[i] = hc[i-1];
    end
    hde[0] = d; hhs[0] = h; hvs[0] = v; hr[0] = r; hc[0] = c;
    @(posedge clk);
    #1;
    if (de1 !== hde[2] || hs1 !== hhs[2] || vs1 !== hvs[2]) sync_err++;
    if (de0 !== hde[2] || hs0 !== hhs[2] || vs0 !== hvs[2]) sync_err++;
    if (hde[2] === 1'b1) begin
      cap1[hr[2]][hc[2]] = dout1;
      cap0[hr[2]][hc[2]] = dout0;
    end
  endtask

  // Drives one frame from img. erode_en flips at the start of tog_row (if >= 0).
  // With vs_with_de the vsync rising edge lands on the first pixel.
  task automatic run_frame(input bit en, input int tog_row, input bit vs_with_de);
    logic [7:0] x;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        cap1[r][c] = 8'h55;
        cap0[r][c] = 8'h55;
      end
    sync_err = 0;
    erode_en = en;
    if (!vs_with_de) begin
      cycle(1'b0, 1'b0, 1'b1, 8'hA5, 0, 0);
      cycle(1'b0, 1'b0, 1'b1, 8'hA5, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 8'hA5, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 8'hA5, 0, 0);
    end
    for (int r = 0; r < V; r++) begin
      if (r == tog_row) erode_en = ~en;
      for (int c = 0; c < H; c++) begin
        x = img[r][c] ? 8'($urandom_range(255, 1)) : 8'h00;
        cycle(1'b1, 1'b0, (vs_with_de && r == 0 && c < 2), x, r, c);
      end
      cycle(1'b0, 1'b1, 1'b0, 8'hFF, 0, 0);
      cycle(1'b0, 1'b1, 1'b0, 8'hFF, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 8'hFF, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 8'hFF, 0, 0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  // Reference erosion straight from the definition on the stored image.
  function automatic logic [7:0] model(input int r, input int c, input bit bv, input bit en);
    bit acc;
    bit tap;
    if (!en) return img[r][c] ? 8'hFF : 8'h00;
    acc = 1'b1;
    for (int rr = r - 2; rr <= r; rr++)
      for (int cc = c - 2; cc <= c; cc++) begin
        tap = (rr < 0 || cc < 0) ? bv : img[rr][cc];
        acc = acc & tap;
      end
    return acc ? 8'hFF : 8'h00;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        case (mode)
          0:       img[r][c] = 1'b0;
          1:       img[r][c] = 1'b1;
          default: img[r][c] = ($urandom_range(9, 0) != 0);
        endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b1; erode_en = 1'b1; de = 1'b1; hs = 1'b1; vs = 1'b1; din = 8'hFF;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({de1, hs1, vs1, dout1} !== 11'd0) begin
      bad++;
      $display("FAIL reset_bv1: got %b expected 0", {de1, hs1, vs1, dout1});
    end
    total++;
    if ({de0, hs0, vs0, dout0} !== 11'd0) begin
      bad++;
      $display("FAIL reset_bv0: got %b expected 0", {de0, hs0, vs0, dout0});
    end
    de = 1'b0; hs = 1'b0; vs = 1'b0; din = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_hist();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic test_all_ff();
    logic [7:0] e0;
    fill(1);
    run_frame(1'b1, -1, 1'b0);
    total++;
    if (sync_err !== 0) begin
      bad++;
      $display("FAIL all_ff_sync: %0d misaligned sync cycles, expected 0", sync_err);
    end
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        total++;
        if (cap1[r][c] !== 8'hFF) begin
          bad++;
          $display("FAIL all_ff_bv1 (%0d,%0d): got %h expected ff", r, c, cap1[r][c]);
        end
        e0 = (r < 2 || c < 2) ? 8'h00 : 8'hFF;
        total++;
        if (cap0[r][c] !== e0) begin
          bad++;
          $display("FAIL all_ff_bv0 (%0d,%0d): got %h expected %h", r, c, cap0[r][c], e0);
        end
      end
  endtask

  task automatic test_hole();
    logic [7:0] e1;
    fill(1);
    img[10][20] = 1'b0;
    run_frame(1'b1, -1, 1'b0);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        e1 = (r >= 10 && r <= 12 && c >= 20 && c <= 22) ? 8'h00 : 8'hFF;
        total++;
        if (cap1[r][c] !== e1) begin
          bad++;
          $display("FAIL hole_bv1 (%0d,%0d): got %h expected %h", r, c, cap1[r][c], e1);
        end
        total++;
        if (cap0[r][c] !== model(r, c, 1'b0, 1'b1)) begin
          bad++;
          $display("FAIL hole_bv0 (%0d,%0d): got %h expected %h", r, c, cap0[r][c],
                   model(r, c, 1'b0, 1'b1));
        end
      end
  endtask

  task automatic test_single_dot();
    logic [7:0] eb;
    fill(0);
    img[5][7] = 1'b1;
    run_frame(1'b1, -1, 1'b0);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        total++;
        if (cap1[r][c] !== 8'h00 || cap0[r][c] !== 8'h00) begin
          bad++;
          $display("FAIL dot_erode (%0d,%0d): got %h/%h expected 00/00", r, c,
                   cap1[r][c], cap0[r][c]);
        end
      end
    run_frame(1'b0, -1, 1'b0);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        eb = (r == 5 && c == 7) ? 8'hFF : 8'h00;
        total++;
        if (cap1[r][c] !== eb || cap0[r][c] !== eb) begin
          bad++;
          $display("FAIL dot_bypass (%0d,%0d): got %h/%h expected %h", r, c,
                   cap1[r][c], cap0[r][c], eb);
        end
      end
    total++;
    if (sync_err !== 0) begin
      bad++;
      $display("FAIL dot_bypass_sync: %0d misaligned sync cycles, expected 0", sync_err);
    end
  endtask

  task automatic check_model(input string name, input bit en);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        total++;
        if (cap1[r][c] !== model(r, c, 1'b1, en) || cap0[r][c] !== model(r, c, 1'b0, en)) begin
          bad++;
          $display("FAIL %s (%0d,%0d): got %h/%h expected %h/%h", name, r, c, cap1[r][c],
                   cap0[r][c], model(r, c, 1'b1, en), model(r, c, 1'b0, en));
        end
      end
    total++;
    if (sync_err !== 0) begin
      bad++;
      $display("FAIL %s_sync: %0d misaligned sync cycles, expected 0", name, sync_err);
    end
  endtask

  task automatic test_en_toggle();
    fill(2);
    run_frame(1'b1, 6, 1'b0);
    check_model("toggle_a_eroded", 1'b1);
    fill(2);
    run_frame(1'b0, 6, 1'b0);
    check_model("toggle_b_bypass", 1'b0);
    fill(2);
    run_frame(1'b1, -1, 1'b0);
    check_model("toggle_c_eroded", 1'b1);
  endtask

  task automatic test_vs_with_de();
    fill(2);
    run_frame(1'b1, -1, 1'b1);
    check_model("vs_with_de", 1'b1);
  endtask

  task automatic test_reset_mid();
    erode_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    for (int c = 0; c < H; c++) cycle(1'b1, 1'b0, 1'b0, 8'hFF, 0, c);
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0, 1'b0, 8'hFF, 1, c);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({de1, hs1, vs1, dout1, de0, hs0, vs0, dout0} !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got %b/%b expected 0", {de1, hs1, vs1, dout1},
               {de0, hs0, vs0, dout0});
    end
    de = 1'b0; hs = 1'b0; vs = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_hist();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    fill(2);
    run_frame(1'b1, -1, 1'b0);
    check_model("reset_mid_frame", 1'b1);
  endtask

  initial begin
    clear_hist();
    test_reset();
    test_all_ff();
    test_hole();
    test_single_dot();
    test_en_toggle();
    test_vs_with_de();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
